hdmi_stream_crc_monitor: RTL

Terminal sink for the renderer's 24-bit RGB video AXI-Stream. It sits downstream of the voxel pipeline output in `voxel_axil_shell` and stands in for the HDMI transmitter in simulation and bring-up builds. It accepts pixels, tracks line and pixel position, and checks frame framing against the configured geometry. It computes a per-frame CRC-32 and publishes beat, frame and error counters for golden-image regression.

---
 rtl/hdmi_mon_pkg.sv | 36 +++
 rtl/crc32_d24_step.sv | 21 ++
 rtl/hdmi_stream_crc_monitor.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/hdmi_mon_pkg.sv
// Shared types and constants for the HDMI stream CRC monitor and related checkers.
package hdmi_mon_pkg;

    typedef enum logic {
        WAIT_SOF = 1'b0,
        IN_FRAME = 1'b1
    } hdmi_mon_state_e;

    typedef struct packed {
        logic [7:0] byte2;
        logic [7:0] byte1;
        logic [7:0] byte0;
    } rgb_pixel_t;

    localparam int unsigned PIXEL_W = 24;
    localparam int unsigned CRC_W   = 32;
    localparam int unsigned IDX_W   = 16;
    localparam int unsigned ERR_W   = 16;

    localparam logic [CRC_W-1:0] CRC32_POLY_REFL = 32'hEDB88320;
    localparam logic [CRC_W-1:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [CRC_W-1:0] CRC32_XOROUT    = 32'hFFFFFFFF;
    localparam logic [ERR_W-1:0] SYNC_ERR_MAX    = 16'hFFFF;

    // Reflected CRC-32 update for one byte, LSB first.
    function automatic logic [CRC_W-1:0] crc32_fold_byte(input logic [CRC_W-1:0] crc,
                                                         input logic [7:0]       data);
        logic [CRC_W-1:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY_REFL) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d24_step.sv
// Combinational CRC-32 step over one 24-bit pixel, folded byte0, byte1, byte2.
module crc32_d24_step
    import hdmi_mon_pkg::*;
(
    input  logic [CRC_W-1:0]   crc_in,
    input  logic [PIXEL_W-1:0] data_in,
    output logic [CRC_W-1:0]   crc_out
);

    rgb_pixel_t pix;

    assign pix = rgb_pixel_t'(data_in);

    always_comb begin
        crc_out = crc_in;
        crc_out = crc32_fold_byte(crc_out, pix.byte0);
        crc_out = crc32_fold_byte(crc_out, pix.byte1);
        crc_out = crc32_fold_byte(crc_out, pix.byte2);
    end

endmodule

// File: rtl/hdmi_stream_crc_monitor.sv
// Terminal sink for the 24-bit RGB video stream: framing checks, per-frame CRC-32, counters.
// Define HDMI_MON_BACKPRESSURE_EN to throttle tready with a 16-bit LFSR.
module hdmi_stream_crc_monitor
    import hdmi_mon_pkg::*;
#(
    parameter int unsigned SCREEN_WIDTH  = 32,
    parameter int unsigned SCREEN_HEIGHT = 24
`ifdef HDMI_MON_BACKPRESSURE_EN
    ,
    parameter logic [15:0] THROTTLE_SEED = 16'hACE1
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [PIXEL_W-1:0] s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tlast,
    input  logic               s_axis_tuser,
    input  logic               err_clr,
    output logic [31:0]        hdmi_beat_count,
    output logic [31:0]        hdmi_frame_count,
    output logic [CRC_W-1:0]   hdmi_crc_last,
    output logic [IDX_W-1:0]   hdmi_line_count,
    output logic [IDX_W-1:0]   hdmi_pixel_in_line,
    output logic               frame_done,
    output logic [ERR_W-1:0]   sync_err_count
);

    localparam logic [IDX_W-1:0] LAST_PIX  = IDX_W'(SCREEN_WIDTH - 1);
    localparam logic [IDX_W-1:0] LAST_LINE = IDX_W'(SCREEN_HEIGHT - 1);

    hdmi_mon_state_e  state_q, state_d;
    logic [CRC_W-1:0] crc_q, crc_d;
    logic [CRC_W-1:0] crc_seed_c, crc_next_c;
    logic [IDX_W-1:0] pix_q, pix_d;
    logic [IDX_W-1:0] line_q, line_d;
    logic [31:0]      beat_q, beat_d;
    logic [31:0]      frame_q, frame_d;
    logic [CRC_W-1:0] crc_last_q, crc_last_d;
    logic             done_q, done_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             ready_q;

    logic             accept_c;
    logic [IDX_W-1:0] cur_pix_c, cur_line_c;
    logic             at_last_pix_c;
    logic [1:0]       err_inc_c;
    logic [ERR_W:0]   err_sum_c;

    assign accept_c   = s_axis_tvalid && ready_q;
    // A start-of-frame beat always restarts the CRC, whether or not a frame was open.
    assign crc_seed_c = s_axis_tuser ? CRC32_INIT : crc_q;

    crc32_d24_step u_crc_step (
        .crc_in  (crc_seed_c),
        .data_in (s_axis_tdata),
        .crc_out (crc_next_c)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= WAIT_SOF;
            crc_q      <= CRC32_INIT;
            pix_q      <= '0;
            line_q     <= '0;
            beat_q     <= '0;
            frame_q    <= '0;
            crc_last_q <= '0;
            done_q     <= 1'b0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            crc_q      <= crc_d;
            pix_q      <= pix_d;
            line_q     <= line_d;
            beat_q     <= beat_d;
            frame_q    <= frame_d;
            crc_last_q <= crc_last_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        crc_d         = crc_q;
        pix_d         = pix_q;
        line_d        = line_q;
        beat_d        = beat_q;
        frame_d       = frame_q;
        crc_last_d    = crc_last_q;
        done_d        = 1'b0;
        err_inc_c     = 2'd0;
        cur_pix_c     = pix_q;
        cur_line_c    = line_q;
        at_last_pix_c = 1'b0;
        err_sum_c     = '0;

        if (accept_c) begin
            beat_d = beat_q + 32'd1;
            if (state_q == WAIT_SOF && !s_axis_tuser) begin
                err_inc_c = 2'd1;
            end else begin
                if (s_axis_tuser) begin
                    cur_pix_c  = '0;
                    cur_line_c = '0;
                end
                if (state_q == IN_FRAME && s_axis_tuser) begin
                    err_inc_c = err_inc_c + 2'd1;
                end
                crc_d         = crc_next_c;
                state_d       = IN_FRAME;
                at_last_pix_c = (cur_pix_c == LAST_PIX);
                if (s_axis_tlast || at_last_pix_c) begin
                    // Early tlast or missing tlast both count as one framing error.
                    if (s_axis_tlast != at_last_pix_c) begin
                        err_inc_c = err_inc_c + 2'd1;
                    end
                    pix_d = '0;
                    if (cur_line_c == LAST_LINE) begin
                        crc_last_d = crc_next_c ^ CRC32_XOROUT;
                        frame_d    = frame_q + 32'd1;
                        done_d     = 1'b1;
                        line_d     = '0;
                        state_d    = WAIT_SOF;
                    end else begin
                        line_d = cur_line_c + IDX_W'(1);
                    end
                end else begin
                    pix_d = cur_pix_c + IDX_W'(1);
                end
            end
        end

        err_sum_c = {1'b0, err_q} + (ERR_W + 1)'(err_inc_c);
        if (err_sum_c > {1'b0, SYNC_ERR_MAX}) begin
            err_d = SYNC_ERR_MAX;
        end else begin
            err_d = err_sum_c[ERR_W-1:0];
        end
        if (err_clr) begin
            err_d = '0;
        end
    end

`ifdef HDMI_MON_BACKPRESSURE_EN
    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Fibonacci LFSR, taps 16/14/13/11; tready mirrors bit 0.
    assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_q  <= THROTTLE_SEED;
            ready_q <= 1'b0;
        end else begin
            lfsr_q  <= lfsr_d;
            ready_q <= lfsr_d[0];
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end
`endif

    assign s_axis_tready      = ready_q;
    assign hdmi_beat_count    = beat_q;
    assign hdmi_frame_count   = frame_q;
    assign hdmi_crc_last      = crc_last_q;
    assign hdmi_line_count    = line_q;
    assign hdmi_pixel_in_line = pix_q;
    assign frame_done         = done_q;
    assign sync_err_count     = err_q;

endmodule
